dmem_bytelane_ws: RTL and testbench

Parametrised data memory for the MEM stage of the pipelined MIPS core. It supports byte, halfword and word loads and stores, with sign or zero extension on loads and little-endian lanes. It adds configurable wait states with a stall handshake to the pipeline, detection of misaligned and out-of-range accesses, and a sequential clear sweep after reset. It replaces the fixed 100-word, word-only data memory and keeps the `test_value` debug tap.

---
 rtl/dmem_bytelane_ws.sv | 175 +++++++++++++++++
 tb/tb_dmem_bytelane_ws.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane_ws.sv
// Byte-lane data memory for the MEM stage: sized/extended loads and stores,
// optional wait states with a stall handshake, fault detection and a post-reset clear sweep.
module dmem_bytelane_ws #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned TEST_IDX    = 0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        RE,
    input  logic        WE,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        stall,
    output logic        busy,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] test_value
);

    localparam int unsigned  AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0]  DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]   WC      = 4'(WAIT_CYCLES);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] TIDX   = AW'(TEST_IDX);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   clr_idx, clr_idx_nx;
    logic [3:0]      wcnt, wcnt_nx;
    logic            done;
    logic            fault_seen;

    logic [31:0]     mem [DEPTH];

    logic            req, is_half, is_word, misalign, in_range, bad;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic [31:0]     wdata, rd_word, shifted, ld_data;
    logic            wr_commit, rd_commit;

    // Request decode
    assign req      = RE | WE;
    assign is_half  = (size == 2'b01);
    assign is_word  = size[1];
    assign idx      = A[AW+1:2];
    assign in_range = (A[31:2] < DEPTH_W);
    assign misalign = (is_half & A[0]) | (is_word & (A[1:0] != 2'b00));
    assign bad      = misalign | ~in_range;
    assign fault    = req & bad & (state == S_IDLE);

    // Store lane enables and replicated data
    always_comb begin
        be    = 4'b1111;
        wdata = WD;
        if (size == 2'b00) begin
            be    = 4'(4'b0001 << A[1:0]);
            wdata = {4{WD[7:0]}};
        end else if (is_half) begin
            be    = A[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WD[15:0]}};
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        wcnt_nx    = wcnt;
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_CLEAR: begin
                busy       = 1'b1;
                stall      = 1'b1;
                clr_idx_nx = clr_idx + AW'(1);
                if (clr_idx == LAST) begin
                    clr_idx_nx = '0;
                    state_nx   = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req && !bad) begin
                    if (WAIT_CYCLES == 0) begin
                        done = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        wcnt_nx  = 4'd1;
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt < WC) begin
                    stall   = 1'b1;
                    wcnt_nx = wcnt + 4'd1;
                end else begin
                    done     = 1'b1;
                    wcnt_nx  = 4'd0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx   = S_CLEAR;
                clr_idx_nx = '0;
                wcnt_nx    = 4'd0;
            end
        endcase
    end

    assign wr_commit = done & WE;
    assign rd_commit = done & RE & ~WE;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            wcnt    <= 4'd0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
            wcnt    <= wcnt_nx;
        end
    end

    // Sticky address of the first faulting request
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            fault_addr <= 32'd0;
            fault_seen <= 1'b0;
        end else if (fault && !fault_seen) begin
            fault_addr <= A;
            fault_seen <= 1'b1;
        end
    end

    // Storage array: clear sweep has priority, then lane-masked stores
    always_ff @(posedge CLK) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= 32'd0;
        end else if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Load extraction; half loads are aligned so the byte shift covers both sizes
    assign rd_word = mem[idx];
    assign shifted = rd_word >> {A[1:0], 3'b000};

    always_comb begin
        ld_data = rd_word;
        if (size == 2'b00) begin
            ld_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            ld_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
        end
    end

    assign RD         = rd_commit ? ld_data : 32'd0;
    assign test_value = mem[TIDX];

endmodule

// File: tb/tb_dmem_bytelane_ws.sv
// Directed bench: vector table on a zero-wait instance, hand sequences for wait states and reset abort.
module tb_dmem_bytelane_ws;

    logic        CLK;
    logic        reset;
    logic        re0, we0, re3, we3, re2, we2;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] A, WD;

    logic [31:0] rd0, fa0, tv0, rd3, fa3, tv3, rd2, fa2, tv2;
    logic        stall0, busy0, fault0, stall3, busy3, fault3, stall2, busy2, fault2;

    int checks = 0;
    int errors = 0;

    dmem_bytelane_ws #(.DEPTH(8), .WAIT_CYCLES(0), .TEST_IDX(1)) u0 (
        .CLK(CLK), .reset(reset), .RE(re0), .WE(we0), .size(size), .uns(uns), .A(A), .WD(WD),
        .RD(rd0), .stall(stall0), .busy(busy0), .fault(fault0), .fault_addr(fa0), .test_value(tv0));

    dmem_bytelane_ws #(.DEPTH(8), .WAIT_CYCLES(3), .TEST_IDX(2)) u3 (
        .CLK(CLK), .reset(reset), .RE(re3), .WE(we3), .size(size), .uns(uns), .A(A), .WD(WD),
        .RD(rd3), .stall(stall3), .busy(busy3), .fault(fault3), .fault_addr(fa3), .test_value(tv3));

    dmem_bytelane_ws #(.DEPTH(8), .WAIT_CYCLES(2), .TEST_IDX(3)) u2 (
        .CLK(CLK), .reset(reset), .RE(re2), .WE(we2), .size(size), .uns(uns), .A(A), .WD(WD),
        .RD(rd2), .stall(stall2), .busy(busy2), .fault(fault2), .fault_addr(fa2), .test_value(tv2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        flt;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_sweep(input string name, input logic which);
        int n;
        n = 0;
        while ((which ? busy2 : busy0) && n < 100) begin
            @(posedge CLK);
            n++;
            #1;
        end
        check(name, 32'(n), 32'd8);
    endtask

    initial begin
        tv[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h1C, 32'h0,        32'h0,        1'b0};
        tv[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h11223344, 32'h0,        1'b0};
        tv[2]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h04, 32'h0,        32'h44,       1'b0};
        tv[3]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h05, 32'h0,        32'h33,       1'b0};
        tv[4]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h06, 32'h0,        32'h22,       1'b0};
        tv[5]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h07, 32'h0,        32'h11,       1'b0};
        tv[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h06, 32'h1234BEEF, 32'h0,        1'b0};
        tv[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0,        32'hBEEF3344, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h06, 32'h0,        32'hFFFFBEEF, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h06, 32'h0,        32'h0000BEEF, 1'b0};
        tv[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h07, 32'h0,        32'hFFFFFFBE, 1'b0};
        tv[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h05, 32'h555555AA, 32'h0,        1'b0};
        tv[12] = '{1'b0, 1'b1, 2'd2, 1'b1, 32'h04, 32'h0,        32'hBEEFAA44, 1'b0};
        tv[13] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0A, 32'hDEADBEEF, 32'h0,        1'b1};
        tv[14] = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h03, 32'h0,        32'h0,        1'b1};
        tv[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h0,        32'h0,        1'b0};
        tv[16] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h99,       32'h0,        1'b1};
        tv[17] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
        tv[18] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0,        32'h0,        1'b1};
        tv[19] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0C, 32'h01020304, 32'h0,        1'b0};
        tv[20] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h0,        32'h01020304, 1'b0};
        tv[21] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0C, 32'h0,        32'h00000004, 1'b0};
        tv[22] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0E, 32'h0,        32'h00000102, 1'b0};

        // Reset with a misaligned load held: no fault, no data, stalled
        reset = 1'b0;
        re0 = 1'b1; we0 = 1'b0; re3 = 1'b0; we3 = 1'b0; re2 = 1'b0; we2 = 1'b0;
        size = 2'd2; uns = 1'b0; A = 32'h0A; WD = 32'h0;
        #1;
        check("rst_stall", 32'(stall0), 32'd1);
        check("rst_busy",  32'(busy0),  32'd1);
        check("rst_fault", 32'(fault0), 32'd0);
        check("rst_rd",    rd0,         32'd0);
        #11;
        reset = 1'b1;
        re0   = 1'b0;
        count_sweep("sweep_len", 1'b0);
        check("sweep_stall", 32'(stall0), 32'd0);
        check("sweep_fa",    fa0,         32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            we0 = tv[i].we; re0 = tv[i].re; size = tv[i].sz; uns = tv[i].un;
            A = tv[i].a; WD = tv[i].wd;
            #1;
            check($sformatf("v%0d_rd", i),    rd0,            tv[i].rd);
            check($sformatf("v%0d_fault", i), 32'(fault0),    32'(tv[i].flt));
            check($sformatf("v%0d_stall", i), 32'(stall0),    32'd0);
        end
        @(negedge CLK);
        we0 = 1'b0; re0 = 1'b0;
        #1;
        check("fault_addr_sticky", fa0, 32'h0A);
        check("test_value_u0",     tv0, 32'hBEEFAA44);

        // Three wait states: store commits only on the completion edge
        @(negedge CLK);
        size = 2'd2; uns = 1'b0; A = 32'h08; WD = 32'hCAFEF00D; we3 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge CLK);
            #1;
            check($sformatf("u3_st_stall%0d", c), 32'(stall3), (c < 4) ? 32'd1 : 32'd0);
            check($sformatf("u3_st_pre%0d", c),   tv3,          32'd0);
            @(posedge CLK);
        end
        #1;
        check("u3_st_commit", tv3, 32'hCAFEF00D);
        @(negedge CLK);
        we3 = 1'b0; re3 = 1'b1; WD = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge CLK);
            #1;
            check($sformatf("u3_ld_stall%0d", c), 32'(stall3), (c < 4) ? 32'd1 : 32'd0);
            if (c == 4) check("u3_ld_rd", rd3, 32'hCAFEF00D);
            @(posedge CLK);
        end
        @(negedge CLK);
        re3 = 1'b0;
        #1;
        check("u3_idle_stall", 32'(stall3), 32'd0);

        // Two wait states, reset pulsed in the second stalled cycle aborts the store
        @(negedge CLK);
        size = 2'd2; A = 32'h0C; WD = 32'h5; we2 = 1'b1;
        #1;
        check("u2_stall1", 32'(stall2), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("u2_rst_tv",    tv2,          32'd0);
        check("u2_rst_busy",  32'(busy2),   32'd1);
        check("u2_rst_stall", 32'(stall2),  32'd1);
        #1;
        reset = 1'b1;
        we2   = 1'b0;
        count_sweep("u2_sweep_len", 1'b1);
        check("u2_tv_after",    tv2,         32'd0);
        check("u2_stall_after", 32'(stall2), 32'd0);
        check("u0_fa_reset",    fa0,         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
